// File: rtl/wb_pkg.sv
// wb_pkg: state encoding shared by the Wishbone arbiter and its users
package wb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } wb_state_e;
endpackage

// File: rtl/wishbone_arbiter.sv
// wishbone_arbiter: two-master round-robin arbiter for one shared Wishbone slave
// Ports: clk_i/rst_i (async active-high); wbm0_*/wbm1_* master ports
// (cyc/stb/we/adr/dat in, ack/err/rty/dat out); wbs_* shared slave port.
// A master keeps the slave until it drops cyc or the watchdog fires.
module wishbone_arbiter
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 24,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wbm0_cyc_i,
  input  logic                  wbm0_stb_i,
  input  logic                  wbm0_we_i,
  input  logic [ADDR_WIDTH-1:0] wbm0_adr_i,
  input  logic [7:0]            wbm0_dat_i,
  output logic                  wbm0_ack_o,
  output logic                  wbm0_err_o,
  output logic                  wbm0_rty_o,
  output logic [7:0]            wbm0_dat_o,
  input  logic                  wbm1_cyc_i,
  input  logic                  wbm1_stb_i,
  input  logic                  wbm1_we_i,
  input  logic [ADDR_WIDTH-1:0] wbm1_adr_i,
  input  logic [7:0]            wbm1_dat_i,
  output logic                  wbm1_ack_o,
  output logic                  wbm1_err_o,
  output logic                  wbm1_rty_o,
  output logic [7:0]            wbm1_dat_o,
  output logic                  wbs_cyc_o,
  output logic                  wbs_stb_o,
  output logic                  wbs_we_o,
  output logic [ADDR_WIDTH-1:0] wbs_adr_o,
  output logic [7:0]            wbs_dat_o,
  input  logic                  wbs_ack_i,
  input  logic                  wbs_err_i,
  input  logic                  wbs_rty_i,
  input  logic [7:0]            wbs_dat_i
);
  localparam int WD_W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
  wb_state_e state_q, state_d;
  logic last_q, last_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic g0, g1, own_cyc, own_stb, resp, tmo;
  always_comb begin
    g0 = state_q == GRANT0;
    g1 = state_q == GRANT1;
    own_cyc = (g0 & wbm0_cyc_i) | (g1 & wbm1_cyc_i);
    own_stb = (g0 & wbm0_stb_i) | (g1 & wbm1_stb_i);
    resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
    // a real slave response in the expiry cycle beats the watchdog
    tmo = (TIMEOUT_CYCLES != 0) && (g0 || g1) && wd_q == WD_MAX && !resp;
    // last_q = 1 means master 1 was served last, so master 0 wins a tie
    state_d = tmo ? IDLE
      : g0 ? (wbm0_cyc_i ? GRANT0 : wbm1_cyc_i ? GRANT1 : IDLE)
      : g1 ? (wbm1_cyc_i ? GRANT1 : wbm0_cyc_i ? GRANT0 : IDLE)
      : (wbm0_cyc_i && wbm1_cyc_i) ? (last_q ? GRANT0 : GRANT1)
      : wbm0_cyc_i ? GRANT0 : wbm1_cyc_i ? GRANT1 : IDLE;
    last_d = state_d == GRANT0 ? 1'b0 : state_d == GRANT1 ? 1'b1 : last_q;
    wd_d = (TIMEOUT_CYCLES == 0 || state_d != state_q || resp) ? '0
      : (own_cyc && own_stb) ? wd_q + 1'b1 : wd_q;
  end
  assign wbs_cyc_o  = own_cyc & ~tmo;
  assign wbs_stb_o  = own_stb & ~tmo;
  assign wbs_we_o   = (g0 & wbm0_we_i) | (g1 & wbm1_we_i);
  assign wbs_adr_o  = g0 ? wbm0_adr_i : g1 ? wbm1_adr_i : '0;
  assign wbs_dat_o  = g0 ? wbm0_dat_i : g1 ? wbm1_dat_i : '0;
  assign wbm0_ack_o = g0 & wbs_ack_i;
  assign wbm0_err_o = g0 & (wbs_err_i | tmo);
  assign wbm0_rty_o = g0 & wbs_rty_i;
  assign wbm1_ack_o = g1 & wbs_ack_i;
  assign wbm1_err_o = g1 & (wbs_err_i | tmo);
  assign wbm1_rty_o = g1 & wbs_rty_i;
  assign wbm0_dat_o = wbs_dat_i;
  assign wbm1_dat_o = wbs_dat_i;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end
endmodule

// File: tb/tb_wishbone_arbiter.sv
// tb_wishbone_arbiter: table, directed and random checks against a transaction-level model
module tb_wishbone_arbiter;
  localparam int AW = 24;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst;
  logic m0c, m0s, m0w, m1c, m1s, m1w;
  logic [AW-1:0] m0a, m1a;
  logic [7:0] m0d, m1d, sd;
  logic sa, se, sr;
  logic a0, e0, r0, a1, e1, r1;
  logic [7:0] d0, d1;
  logic wc, ws, ww;
  logic [AW-1:0] wa;
  logic [7:0] wd;
  int pass = 0;
  int total = 0;
  int own;
  logic last;
  int wt;
  typedef struct {
    logic c0, c1, ack, ecyc;
    logic [AW-1:0] eadr;
    logic ea0, ea1;
  } vec_t;
  vec_t tbl [9];
  wishbone_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .wbm0_cyc_i(m0c), .wbm0_stb_i(m0s), .wbm0_we_i(m0w), .wbm0_adr_i(m0a), .wbm0_dat_i(m0d),
    .wbm0_ack_o(a0), .wbm0_err_o(e0), .wbm0_rty_o(r0), .wbm0_dat_o(d0),
    .wbm1_cyc_i(m1c), .wbm1_stb_i(m1s), .wbm1_we_i(m1w), .wbm1_adr_i(m1a), .wbm1_dat_i(m1d),
    .wbm1_ack_o(a1), .wbm1_err_o(e1), .wbm1_rty_o(r1), .wbm1_dat_o(d1),
    .wbs_cyc_o(wc), .wbs_stb_o(ws), .wbs_we_o(ww), .wbs_adr_o(wa), .wbs_dat_o(wd),
    .wbs_ack_i(sa), .wbs_err_i(se), .wbs_rty_i(sr), .wbs_dat_i(sd)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
  endtask
  function automatic logic tmo_now();
    return own >= 0 && wt == TO && !(sa | se | sr);
  endfunction
  task automatic model_reset();
    own = -1;
    last = 1'b1;
    wt = 0;
  endtask
  task automatic mcheck();
    logic oc, os, t;
    logic [34:0] ew;
    logic [5:0] er;
    oc = own == 0 ? m0c : own == 1 ? m1c : 1'b0;
    os = own == 0 ? m0s : own == 1 ? m1s : 1'b0;
    t = tmo_now();
    ew = own == 0 ? {oc & ~t, os & ~t, m0w, m0a, m0d}
       : own == 1 ? {oc & ~t, os & ~t, m1w, m1a, m1d} : 35'h0;
    er = {own == 0 && sa, own == 0 && (se || t), own == 0 && sr,
          own == 1 && sa, own == 1 && (se || t), own == 1 && sr};
    chk("wbs_req", 64'({wc, ws, ww, wa, wd}), 64'(ew));
    chk("wbm_resp", 64'({a0, e0, r0, a1, e1, r1}), 64'(er));
    chk("rd_data", 64'({d0, d1}), 64'({sd, sd}));
  endtask
  task automatic model_next();
    int nxt;
    logic oc, os;
    oc = own == 0 ? m0c : own == 1 ? m1c : 1'b0;
    os = own == 0 ? m0s : own == 1 ? m1s : 1'b0;
    if (own < 0) nxt = (m0c && m1c) ? (last ? 0 : 1) : m0c ? 0 : m1c ? 1 : -1;
    else if (tmo_now()) nxt = -1;
    else if (own == 0) nxt = m0c ? 0 : m1c ? 1 : -1;
    else nxt = m1c ? 1 : m0c ? 0 : -1;
    if (nxt != own || sa || se || sr) wt = 0;
    else if (oc && os) wt++;
    if (nxt >= 0) last = (nxt == 1);
    own = nxt;
  endtask
  task automatic adv();
    @(posedge clk);
    model_next();
    @(negedge clk);
  endtask
  task automatic cycle();
    #1 mcheck();
    adv();
  endtask
  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 24'h000100, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000100, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 24'h800010, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 24'h800010, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 24'h000100, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 24'h000100, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0};
    rst = 1'b1;
    {m0s, m0w, m1s, m1w, se, sr} = '0;
    m0c = 1'b1; m1c = 1'b1; sa = 1'b1;
    m0a = 24'h000100; m1a = 24'h800010; m0d = 8'h11; m1d = 8'h22; sd = 8'h5A;
    model_reset();
    repeat (2) @(negedge clk);
    #1 chk("rst_wbs", 64'({wc, ws, ww, wa, wd}), 64'(0));
    chk("rst_resp", 64'({a0, e0, r0, a1, e1, r1}), 64'(0));
    @(negedge clk);
    rst = 1'b0; m0c = 1'b0; m1c = 1'b0; sa = 1'b0;
    for (int i = 0; i < 9; i++) begin
      m0c = tbl[i].c0; m0s = tbl[i].c0; m1c = tbl[i].c1; m1s = tbl[i].c1; sa = tbl[i].ack;
      #1 chk($sformatf("tbl%0d_cyc", i), 64'(wc), 64'(tbl[i].ecyc));
      chk($sformatf("tbl%0d_adr", i), 64'(wa), 64'(tbl[i].eadr));
      chk($sformatf("tbl%0d_acks", i), 64'({a0, a1}), 64'({tbl[i].ea0, tbl[i].ea1}));
      mcheck();
      adv();
    end
    m1c = 1'b1; m1s = 1'b1; m1a = 24'h800010;
    #1 chk("single_lat0", 64'(wc), 64'(0));
    mcheck();
    adv();
    #1 chk("single_lat1", 64'({wc, wa}), 64'({1'b1, 24'h800010}));
    mcheck();
    adv();
    cycle();
    sa = 1'b1;
    #1 chk("single_ack", 64'({a0, a1}), 64'({1'b0, 1'b1}));
    mcheck();
    adv();
    sa = 1'b0; m1c = 1'b0; m1s = 1'b0;
    cycle();
    m0c = 1'b1; m0s = 1'b1; m0a = 24'h000200;
    cycle();
    for (int i = 0; i < 3; i++) begin
      m0a = 24'h000200 + 24'(i); sa = 1'b1;
      if (i == 1) begin m1c = 1'b1; m1s = 1'b1; m1a = 24'h800020; end
      #1 chk($sformatf("nopre_adr%0d", i), 64'(wa), 64'(24'h000200 + 24'(i)));
      mcheck();
      adv();
    end
    m0c = 1'b0; m0s = 1'b0; sa = 1'b0;
    #1 chk("nopre_drop", 64'(wa), 64'(24'h000202));
    mcheck();
    adv();
    #1 chk("nopre_handover", 64'({wc, wa}), 64'({1'b1, 24'h800020}));
    mcheck();
    adv();
    m1c = 1'b0; m1s = 1'b0;
    cycle();
    m0c = 1'b1; m0s = 1'b1; m0a = 24'h000300;
    cycle();
    for (int k = 1; k <= 5; k++) begin
      #1 chk($sformatf("tmo_err%0d", k), 64'({e0, e1}), 64'({k == 5, 1'b0}));
      chk($sformatf("tmo_cyc%0d", k), 64'(wc), 64'(k != 5));
      mcheck();
      adv();
    end
    m0c = 1'b0; m0s = 1'b0;
    #1 chk("tmo_idle", 64'({wc, e0}), 64'(0));
    mcheck();
    adv();
    m1c = 1'b1; m1s = 1'b1; m1a = 24'h800030;
    cycle();
    #1 chk("arst_pre", 64'(wc), 64'(1));
    #2 rst = 1'b1; sa = 1'b1;
    #1 chk("arst_wbs", 64'({wc, ws, ww, wa, wd}), 64'(0));
    chk("arst_resp", 64'({a0, e0, r0, a1, e1, r1}), 64'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0; sa = 1'b0;
    #1 chk("arst_idle", 64'(wc), 64'(0));
    mcheck();
    adv();
    m1c = 1'b0; m1s = 1'b0;
    cycle();
    for (int i = 0; i < 600; i++) begin
      int r;
      if ($urandom_range(0, 3) == 0) m0c = ~m0c;
      if ($urandom_range(0, 3) == 0) m1c = ~m1c;
      m0s = $urandom_range(0, 3) != 0; m1s = $urandom_range(0, 3) != 0;
      m0w = 1'($urandom); m1w = 1'($urandom);
      m0a = 24'($urandom); m1a = 24'($urandom);
      m0d = 8'($urandom); m1d = 8'($urandom); sd = 8'($urandom);
      r = $urandom_range(0, 19);
      if (i >= 300) r = r + 8;
      sa = r < 8; se = r == 8 || r == 9; sr = r == 10;
      cycle();
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
